// File: rtl/booth_mult.sv
// Sequential signed radix-2 Booth multiplier for MULT.
// One Booth step per clock; hi/lo are updated only when the product is complete.
module booth_mult #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mult_start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             mult_end,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state, state_nxt;
    logic signed [WIDTH:0]   m, acc;
    logic        [WIDTH-1:0] q;
    logic                    q_m1;
    logic        [CNT_W-1:0] count;
    logic                    load;
    logic        [2*WIDTH+1:0] step;
    logic signed [WIDTH:0]   step_acc;
    logic        [WIDTH-1:0] step_q;
    logic                    step_qm1;

    // acc carries one guard bit so that subtracting the most-negative M cannot overflow
    function automatic logic [2*WIDTH+1:0] booth_step(
        input logic signed [WIDTH:0]   a,
        input logic signed [WIDTH:0]   mm,
        input logic        [WIDTH-1:0] qq,
        input logic                    qm
    );
        logic signed [WIDTH:0]     t;
        logic signed [2*WIDTH+1:0] v;
        case ({qq[0], qm})
            2'b01:   t = a + mm;
            2'b10:   t = a - mm;
            default: t = a;
        endcase
        v = {t, qq, qm};
        return v >>> 1;
    endfunction

    assign step     = booth_step(acc, m, q, q_m1);
    assign step_acc = step[2*WIDTH+1:WIDTH+1];
    assign step_q   = step[WIDTH:1];
    assign step_qm1 = step[0];

    assign busy     = (state == RUN);
    assign mult_end = (state == DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (mult_start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (count == CNT_W'(1)) state_nxt = DONE;
            end
            DONE: begin
                load      = mult_start;
                state_nxt = mult_start ? RUN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m     <= '0;
            acc   <= '0;
            q     <= '0;
            q_m1  <= 1'b0;
            count <= '0;
            hi    <= '0;
            lo    <= '0;
        end else if (load) begin
            m     <= {A[WIDTH-1], A};
            q     <= B;
            acc   <= '0;
            q_m1  <= 1'b0;
            count <= CNT_W'(WIDTH);
        end else if (state == RUN) begin
            acc   <= step_acc;
            q     <= step_q;
            q_m1  <= step_qm1;
            count <= count - 1'b1;
            if (count == CNT_W'(1)) begin
                hi <= step_acc[WIDTH-1:0];
                lo <= step_q;
            end
        end
    end
endmodule
